config_chain_loader: RTL

//  Transmit end of the logic-tile configuration chain: takes the bitstream as parallel words over a

---
 rtl/config_chain_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - parallel bitstream words to serial tile configuration chain driver
// Optional CONFIG_LOADER_READBACK_EN: packs the chain tail into readback words and skips CLEAR.
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 29,
  parameter int WORD_WIDTH   = 8,
  parameter int RESET_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data,
  output logic                  config_enable,
  output logic                  config_nreset
`ifdef CONFIG_LOADER_READBACK_EN
  ,
  input  logic                  config_return,
  output logic [WORD_WIDTH-1:0] readback_data,
  output logic                  readback_valid
`endif
);

  localparam int BW = $clog2(CHAIN_LENGTH + 1);
  localparam int WW = $clog2(WORD_WIDTH + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_WORD, SHIFT, DONE} state_t;

  state_t                state;
  logic [BW-1:0]         bits_sent;
  logic [WW-1:0]         word_left;
  logic [WORD_WIDTH-1:0] shreg;
  logic [RW-1:0]         clr_cnt;
  int                    rem;
  logic [WW-1:0]         word_n;

  // Bits this word contributes; the final word may be truncated.
  assign rem    = CHAIN_LENGTH - int'(bits_sent);
  assign word_n = (rem >= WORD_WIDTH) ? WW'(WORD_WIDTH) : WW'(rem);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      word_ready    <= 1'b0;
      config_data   <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b0;
      bits_sent     <= '0;
      word_left     <= '0;
      shreg         <= '0;
      clr_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          config_nreset <= 1'b1;
          config_enable <= 1'b0;
          config_data   <= 1'b0;
          word_ready    <= 1'b0;
          done          <= 1'b0;
          busy          <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            bits_sent <= '0;
            clr_cnt   <= '0;
`ifdef CONFIG_LOADER_READBACK_EN
            // Chain must keep its old contents so they can be shifted out.
            word_ready <= 1'b1;
            state      <= WAIT_WORD;
`else
            config_nreset <= 1'b0;
            state         <= CLEAR;
`endif
          end
        end
        CLEAR: begin
          if (clr_cnt == RW'(RESET_CYCLES - 1)) begin
            config_nreset <= 1'b1;
            word_ready    <= 1'b1;
            state         <= WAIT_WORD;
          end else begin
            clr_cnt <= clr_cnt + RW'(1);
          end
        end
        WAIT_WORD: begin
          if (word_valid) begin
            word_ready    <= 1'b0;
            config_enable <= 1'b1;
            config_data   <= word_data[0];
            shreg         <= word_data >> 1;
            word_left     <= word_n - WW'(1);
            bits_sent     <= bits_sent + BW'(1);
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (word_left != '0) begin
            config_data <= shreg[0];
            shreg       <= shreg >> 1;
            word_left   <= word_left - WW'(1);
            bits_sent   <= bits_sent + BW'(1);
          end else begin
            config_enable <= 1'b0;
            config_data   <= 1'b0;
            if (bits_sent == BW'(CHAIN_LENGTH)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              word_ready <= 1'b1;
              state      <= WAIT_WORD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONFIG_LOADER_READBACK_EN
  logic [WORD_WIDTH-1:0] rb_word;
  logic [WW-1:0]         rb_cnt;

  // During an enable cycle bits_sent already counts the bit on the wire.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      readback_data  <= '0;
      readback_valid <= 1'b0;
      rb_word        <= '0;
      rb_cnt         <= '0;
    end else begin
      readback_valid <= 1'b0;
      if (config_enable) begin
        if (rb_cnt == WW'(WORD_WIDTH - 1) || bits_sent == BW'(CHAIN_LENGTH)) begin
          readback_data  <= rb_word | (WORD_WIDTH'(config_return) << rb_cnt);
          readback_valid <= 1'b1;
          rb_word        <= '0;
          rb_cnt         <= '0;
        end else begin
          rb_word <= rb_word | (WORD_WIDTH'(config_return) << rb_cnt);
          rb_cnt  <= rb_cnt + WW'(1);
        end
      end
    end
  end
`endif

endmodule
